// File: rtl/axil_lsu_bridge.sv
// LSU single-request port to AXI4-Lite master: lane steering, write strobes, load extension, misalignment check.
// Latency (zero-wait slave): store rsp at T+2, load rsp at T+3, misaligned rsp at T+1; one transaction in flight.
// Backpressure: req_ready only in IDLE, response held until rsp_ready; LSU_BRIDGE_TIMEOUT_EN aborts after TIMEOUT_CYC.
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif

module axil_lsu_bridge #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [`MemAddrBus] req_addr,
  input  logic [`MemBus]     req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [`MemBus]     rsp_rdata,
  output logic               rsp_err,
  output logic [`MemAddrBus] m_axi_awaddr,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [`MemBus]     m_axi_wdata,
  output logic [3:0]         m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  output logic [`MemAddrBus] m_axi_araddr,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [`MemBus]     m_axi_rdata,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RESP} state_t;

  state_t         state, state_nxt;
  logic           aw_done, w_done;
  logic [1:0]     size_q, off_q;
  logic           signed_q;
  logic           misalign, wr_complete, timeout;
  logic [`MemBus] rshift, rext;

  assign misalign    = (req_size == 2'b01 && req_addr[0]) ||
                       (req_size[1] && req_addr[1:0] != 2'b00);
  assign wr_complete = (aw_done || m_axi_awready) && (w_done || m_axi_wready);

`ifdef LSU_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] tmo_cnt;

  // Cleared while idle so it restarts on entry to WR/RD_A and carries through RD_D.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tmo_cnt <= '0;
    else if (state != RESP)   tmo_cnt <= tmo_cnt + 1'b1;
  end
  assign timeout = (tmo_cnt == TMO_LAST);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
`endif

  assign rshift = m_axi_rdata >> {off_q, 3'b000};

  always_comb begin
    rext = rshift;
    case (size_q)
      2'b00:   rext = {{24{signed_q & rshift[7]}}, rshift[7:0]};
      2'b01:   rext = {{16{signed_q & rshift[15]}}, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misalign)    state_nxt = RESP;
          else if (req_we) state_nxt = WR;
          else             state_nxt = RD_A;
        end
      end
      WR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if (wr_complete || timeout) state_nxt = RESP;
      end
      RD_A: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RD_D;
        else if (timeout)  state_nxt = RESP;
      end
      RD_D: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      signed_q     <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= 4'b0000;
      m_axi_araddr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          size_q    <= req_size;
          signed_q  <= req_signed;
          off_q     <= req_addr[1:0];
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= misalign;
          if (!misalign && req_we) begin
            m_axi_awaddr <= {req_addr[31:2], 2'b00};
            case (req_size)
              2'b00: begin
                m_axi_wdata <= {4{req_wdata[7:0]}};
                m_axi_wstrb <= 4'b0001 << req_addr[1:0];
              end
              2'b01: begin
                m_axi_wdata <= {2{req_wdata[15:0]}};
                m_axi_wstrb <= 4'b0011 << req_addr[1:0];
              end
              default: begin
                m_axi_wdata <= req_wdata;
                m_axi_wstrb <= 4'b1111;
              end
            endcase
          end
          if (!misalign && !req_we) m_axi_araddr <= {req_addr[31:2], 2'b00};
        end
        WR: begin
          if (m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wready)  w_done  <= 1'b1;
          if (timeout && !wr_complete) rsp_err <= 1'b1;
        end
        RD_A: if (timeout && !m_axi_arready) rsp_err <= 1'b1;
        RD_D: begin
          if (m_axi_rvalid) rsp_rdata <= rext;
          else if (timeout) rsp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_lsu_bridge.sv
// Bench for axil_lsu_bridge: AXI-Lite slave with programmable stalls plus a byte-addressed reference memory.
module tb_axil_lsu_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rready;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  int total = 0, bad = 0, cyc = 0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, n_rsp = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit r_pend = 1'b0;
  logic [31:0] r_word = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic [31:0] smem [0:63];
  logic [7:0]  ref_b [0:255];

  axil_lsu_bridge #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AC3C3;
  endfunction

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (awvalid) aw_cyc <= aw_cyc + 1;
    if (wvalid)  w_cyc  <= w_cyc + 1;
    if (arvalid) ar_cyc <= ar_cyc + 1;
    if (rsp_valid && rsp_ready) n_rsp <= n_rsp + 1;
  end

  // Slave: stalls each ready by a programmed count; read data appears r_dly cycles after AR (SRAM: next cycle).
  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; r_pend <= 1'b0; rvalid <= 1'b0;
      for (int i = 0; i < 64; i++) smem[i] <= init_word(i);
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready)   ? w_cnt + 1  : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) last_awaddr <= awaddr;
      if (wvalid && wready) begin
        last_wdata <= wdata;
        last_wstrb <= wstrb;
        for (int j = 0; j < 4; j++)
          if (wstrb[j]) smem[awaddr[7:2]][8*j +: 8] <= wdata[8*j +: 8];
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        if (r_dly == 0) begin
          rvalid <= 1'b1;
          rdata  <= smem[araddr[7:2]];
        end else begin
          r_pend <= 1'b1;
          r_cnt  <= 1;
          r_word <= smem[araddr[7:2]];
        end
      end else if (r_pend) begin
        if (r_cnt >= r_dly) begin
          rvalid <= 1'b1;
          rdata  <= r_word;
          r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg, input logic [7:0] a);
    logic [31:0] v;
    int ai;
    ai = int'(a);
    case (sz)
      2'd0: begin
        v = {24'd0, ref_b[ai]};
        if (sg && v[7]) v[31:8] = '1;
      end
      2'd1: begin
        v = {16'd0, ref_b[ai+1], ref_b[ai]};
        if (sg && v[15]) v[31:16] = '1;
      end
      default: v = {ref_b[ai+3], ref_b[ai+2], ref_b[ai+1], ref_b[ai]};
    endcase
    return v;
  endfunction

  // One LSU transaction; expectations come from the reference memory and the alignment rules.
  task automatic run(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input bit tmo,
                     output logic [31:0] rd, output logic er, output int lat);
    int n, t0, ai;
    bit mis;
    logic [31:0] exp_rd;
    mis    = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0) || tmo;
    exp_rd = (we || mis) ? 32'd0 : ref_load(sz, sg, a[7:0]);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk1("req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk1("rsp_valid", rsp_valid, 1'b1);
    rd  = rsp_rdata;
    er  = rsp_err;
    lat = cyc - t0;
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk1("rsp_err", rsp_err, mis);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk1("hold_err", rsp_err, mis);
      chk1("hold_req_ready", req_ready, 1'b0);
    end
    if (we && !mis) begin
      ai = int'(a[7:0]);
      case (sz)
        2'd0: ref_b[ai] = wd[7:0];
        2'd1: begin ref_b[ai] = wd[7:0]; ref_b[ai+1] = wd[15:8]; end
        default: for (int j = 0; j < 4; j++) ref_b[ai+j] = wd[8*j +: 8];
      endcase
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stuck");
  end

  initial begin
    logic [31:0] rd, w;
    logic er;
    int lat, n, a0, w0, ar0, r0;
    bit seen;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = w[8*j +: 8];
    end

    repeat (3) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, 0, 1'b0, rd, er, lat);
    chk("st_word_lat", lat, 2);
    chk("st_word_awaddr", last_awaddr, 32'h10);
    chk("st_word_wstrb", {28'd0, last_wstrb}, 32'hF);
    chk("st_word_wdata", last_wdata, 32'h12345678);

    run(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, 0, 1'b0, rd, er, lat);
    chk("st_byte_wstrb", {28'd0, last_wstrb}, 32'h8);
    chk("st_byte_wdata", last_wdata, 32'hABABABAB);
    chk("st_byte_awaddr", last_awaddr, 32'h10);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld_byte_s", rd, 32'hFFFFFFAB);
    chk("ld_byte_s_lat", lat, 3);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld_byte_u", rd, 32'h000000AB);

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h80017F00, 0, 1'b0, rd, er, lat);
    run(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, 1'b0, rd, er, lat);
    chk("ld_half_s", rd, 32'hFFFF8001);
    chk("ld_half_s_lat", lat, 3);

    ar0 = ar_cyc;
    run(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 1'b0, rd, er, lat);
    chk1("misalign_err", er, 1'b1);
    chk("misalign_lat", lat, 1);
    chk("misalign_no_ar", ar_cyc - ar0, 0);

    w_dly = 5;
    a0 = aw_cyc; w0 = w_cyc; r0 = n_rsp;
    run(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 3, 1'b0, rd, er, lat);
    chk("wstall_aw_cycles", aw_cyc - a0, 1);
    chk("wstall_w_cycles", w_cyc - w0, 6);
    chk("wstall_responses", n_rsp - r0, 1);
    chk("wstall_lat", lat, 7);
    w_dly = 0;

    for (int k = 0; k < 200; k++) begin
      aw_dly = int'($urandom_range(0, 3));
      w_dly  = int'($urandom_range(0, 3));
      ar_dly = int'($urandom_range(0, 3));
      r_dly  = int'($urandom_range(0, 2));
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          {24'd0, 8'($urandom_range(0, 255))}, $urandom, int'($urandom_range(0, 2)), 1'b0,
          rd, er, lat);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0;

`ifdef LSU_BRIDGE_TIMEOUT_EN
    ar_dly = 100000;
    ar0 = ar_cyc;
    run(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 1'b1, rd, er, lat);
    chk("tmo_lat", lat, 17);
    chk("tmo_ar_cycles", ar_cyc - ar0, 16);
    ar_dly = 0;
`endif

    r_dly = 4;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h44;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rready && n < 20) begin @(negedge clk); n++; end
    chk1("mid_rd_d_reached", rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("mrst_rsp_valid", rsp_valid, 1'b0);
    chk1("mrst_rready", rready, 1'b0);
    chk1("mrst_arvalid", arvalid, 1'b0);
    chk1("mrst_awvalid", awvalid, 1'b0);
    chk1("mrst_wvalid", wvalid, 1'b0);
    chk1("mrst_rsp_err", rsp_err, 1'b0);
    chk1("mrst_req_ready", req_ready, 1'b1);
    chk("mrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mrst_araddr", araddr, 32'd0);
    chk("mrst_awaddr", awaddr, 32'd0);
    chk("mrst_wdata", wdata, 32'd0);
    chk("mrst_wstrb", {28'd0, wstrb}, 32'd0);
    rst = 1'b0;
    r_dly = 0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk1("mrst_no_response", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_lsu_bridge.md
Name: axil_lsu_bridge

Overview:
- AXI4-Lite master that turns the core load/store unit's single-request/response interface into AXI4-Lite transactions for the on-chip SRAM slave and peripheral slaves.
- Sits directly upstream of the SRAM slave.
- Handles byte and halfword lane steering, write strobes, load sign/zero extension and misalignment detection.
- One transaction in flight at a time.

Parameters:
TIMEOUT_CYC, 256, cycles a read or write may wait for its slave handshake before it is aborted; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  LSU request valid
req_ready  out  1  bridge can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  in  1  sign-extend a byte/half load
req_addr  in  `MemAddrBus  byte address
req_wdata  in  `MemBus  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  LSU accepts response
rsp_rdata  out  `MemBus  extended load data (0 for stores and errors)
rsp_err  out  1  misaligned or timed-out access
m_axi_awaddr  out  `MemAddrBus  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  `MemBus  lane-steered write data
m_axi_wstrb  out  4  write strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_araddr  out  `MemAddrBus  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  `MemBus  read data
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE.
  - All valids, rready and rsp_valid = 0.
  - rsp_err = 0, rsp_rdata = 0, all AXI address/data/strb outputs = 0.
  - Reset mid-transaction abandons it; no response is produced.
- States: IDLE, WR, RD_A, RD_D, RESP.
- req_ready = 1 only in IDLE. A request is accepted on req_valid & req_ready. Address, data, size, signed and we are registered on acceptance.
- Misalignment check on acceptance:
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]!=0 is misaligned.
  - Misaligned: go to RESP with rsp_err=1 and rsp_rdata=0. No AXI traffic.
- Aligned store: go to WR.
  - awaddr = {addr[31:2],2'b00}.
  - Byte: wstrb = 0001 << addr[1:0], wdata = byte replicated x4.
  - Half: wstrb = 0011 << addr[1:0], wdata = half replicated x2.
  - Word: wstrb = 1111, wdata = req_wdata.
- WR: awvalid and wvalid are asserted together and held with stable payload.
  - Each valid drops independently once its own ready is seen; the channel that completed is remembered.
  - When both have completed, go to RESP with rsp_err=0, rsp_rdata=0. There is no B channel.
  - With a slave that raises awready and wready together in the same cycle as the valids: request accepted at cycle T, valids high at T+1, rsp_valid at T+2.
- Aligned load: go to RD_A. araddr = word-aligned address; arvalid held until arready, then go to RD_D.
- RD_D: rready = 1.
  - On rvalid, capture rdata and shift it right by 8*addr[1:0].
  - Zero- or sign-extend per size/req_signed; a word load passes through.
  - Go to RESP.
  - With the SRAM slave's one-cycle read latency: acceptance at T, arvalid at T+1, rvalid at T+2, rsp_valid at T+3.
- RESP: rsp_valid = 1, held with stable rsp_rdata/rsp_err until rsp_ready, then go to IDLE. A new request cannot be accepted in the same cycle rsp_ready is seen.
- rvalid arriving outside RD_D is ignored (rready=0). AXI valids never drop before their handshake.

Optional Feature:
- Macro: LSU_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR or RD_A, counts every cycle in WR/RD_A/RD_D, and is preserved across the RD_A to RD_D transition.
  - When it reaches TIMEOUT_CYC-1 without completion, all AXI valids and rready are dropped and the bridge goes to RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: no counter; the bridge waits indefinitely. rsp_err is set only by misalignment.

Test Plan:
- Word store 0x12345678 to 0x00000010, slave ready immediately -> awaddr=0x10, wstrb=1111, rsp_valid at T+2, rsp_err=0.
- Byte store 0xAB to 0x00000013 -> wstrb=1000, wdata=0xABABABAB. A following signed byte load from 0x13 returns 0xFFFFFFAB; the unsigned load returns 0x000000AB.
- Half load from 0x00000012, memory word 0x8001_7F00, signed -> rsp_rdata=0xFFFF8001, rsp_valid at T+3.
- Word load from 0x00000006 -> rsp_err=1 and rsp_valid at T+1, with no arvalid ever asserted.
- Slave holds wready low for 5 cycles while awready is immediate -> awvalid drops after 1 cycle, wvalid stays high 6 cycles, exactly one response. Hold rsp_ready low for 3 cycles -> rsp_valid and data stay stable, req_ready=0.
- With LSU_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=16, slave never asserts arready -> arvalid drops and rsp_err=1 after 16 cycles. Separately, assert rst mid-RD_D -> all outputs are 0 the next cycle and no response is produced.
